// File: rtl/fetch_pkg.sv
// Shared fetch-side types and defaults: PC width, PC type, reset vector and step.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] pc_t;

  localparam pc_t RESET_PC_DEFAULT = 32'h0000_0000;
  localparam pc_t PC_STEP_DEFAULT  = 32'd4;

endpackage

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: issues one PC per cycle into a 1-cycle-latency BTB, forms the
// predicted next PC in F1, and shares the BTB PC port with execute-stage branch updates.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter pc_t RESET_PC = RESET_PC_DEFAULT,
  parameter pc_t PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  output logic            fetch_pred_taken,
  output logic [XLEN-1:0] fetch_pred_target,

  input  logic            ex_resolve_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_mispredict,

  output logic [XLEN-1:0] btb_pc,
  output logic [XLEN-1:0] btb_target_addr,
  output logic            btb_branch_taken,
  output logic            btb_branch_update,
  input  logic            btb_hit,
  input  logic [XLEN-1:0] btb_target
);

  pc_t  pc_f0;
  logic f1_valid;
  pc_t  f1_pc;
  logic f1_fresh;
  logic f1_lookup_ok;
  logic held_taken;
  pc_t  held_target;

  logic cur_taken;
  pc_t  cur_target;
  logic adv;
  logic mispredict;
  logic taken_handoff;

  // A resolving branch owns the shared BTB port; the lookup issued that cycle is discarded.
  assign btb_pc            = ex_resolve_valid ? ex_pc : pc_f0;
  assign btb_branch_update = ex_resolve_valid;
  assign btb_branch_taken  = ex_taken;
  assign btb_target_addr   = ex_target;

  // The BTB response is only valid the cycle after the lookup; afterwards use the captured copy.
  assign cur_taken  = f1_fresh ? (f1_lookup_ok & btb_hit) : held_taken;
  assign cur_target = f1_fresh ? btb_target : held_target;

  assign adv           = !f1_valid | fetch_ready;
  assign mispredict    = ex_resolve_valid & ex_mispredict;
  assign taken_handoff = f1_valid & cur_taken & fetch_ready;

  assign fetch_valid       = f1_valid;
  assign fetch_pc          = f1_pc;
  assign fetch_pred_taken  = f1_valid & cur_taken;
  assign fetch_pred_target = cur_taken ? cur_target : f1_pc + PC_STEP;

  // NOTE: state registers use non-blocking assignments so every update in this block
  // sees the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f0        <= RESET_PC;
      f1_valid     <= 1'b0;
      f1_pc        <= '0;
      f1_fresh     <= 1'b0;
      f1_lookup_ok <= 1'b0;
      held_taken   <= 1'b0;
      held_target  <= '0;
    end else if (mispredict) begin
      pc_f0    <= ex_taken ? ex_target : ex_pc + PC_STEP;
      f1_valid <= 1'b0;
    end else if (taken_handoff) begin
      // The sequential PC already sitting in pc_f0 is dropped: one bubble per taken prediction.
      pc_f0    <= cur_target;
      f1_valid <= 1'b0;
    end else if (adv) begin
      f1_pc        <= pc_f0;
      f1_valid     <= 1'b1;
      f1_fresh     <= 1'b1;
      f1_lookup_ok <= !ex_resolve_valid;
      pc_f0        <= pc_f0 + PC_STEP;
    end else if (f1_fresh) begin
      held_taken  <= cur_taken;
      held_target <= cur_target;
      f1_fresh    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed scenarios plus a randomized run
// against a slot-level fetch model with a bench-owned BTB stub.
module tb_fetch_pc_gen;

  logic        clk;
  logic        rst;
  logic        fetch_ready;
  logic        ex_resolve_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_mispredict;
  logic        btb_hit;
  logic [31:0] btb_target;

  logic        fetch_valid, fetch_pred_taken;
  logic [31:0] fetch_pc, fetch_pred_target;
  logic [31:0] btb_pc, btb_target_addr;
  logic        btb_branch_taken, btb_branch_update;

  logic        fetch_valid2, fetch_pred_taken2;
  logic [31:0] fetch_pc2, fetch_pred_target2;
  logic [31:0] btb_pc2, btb_target_addr2;
  logic        btb_branch_taken2, btb_branch_update2;

  int errors = 0;
  int checks = 0;

  fetch_pc_gen #(.RESET_PC(32'h0000_0100), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_pred_taken(fetch_pred_taken), .fetch_pred_target(fetch_pred_target),
    .ex_resolve_valid(ex_resolve_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_mispredict(ex_mispredict),
    .btb_pc(btb_pc), .btb_target_addr(btb_target_addr),
    .btb_branch_taken(btb_branch_taken), .btb_branch_update(btb_branch_update),
    .btb_hit(btb_hit), .btb_target(btb_target)
  );

  fetch_pc_gen #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) dut_wrap (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid2), .fetch_pc(fetch_pc2),
    .fetch_pred_taken(fetch_pred_taken2), .fetch_pred_target(fetch_pred_target2),
    .ex_resolve_valid(ex_resolve_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_mispredict(ex_mispredict),
    .btb_pc(btb_pc2), .btb_target_addr(btb_target_addr2),
    .btb_branch_taken(btb_branch_taken2), .btb_branch_update(btb_branch_update2),
    .btb_hit(btb_hit), .btb_target(btb_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench BTB contents: a fixed pattern of taken branches with targets in 0x1000..0x1FFC.
  function automatic logic tbl_hit(input logic [31:0] pc);
    return pc[4:2] == 3'd3;
  endfunction

  function automatic logic [31:0] tbl_tgt(input logic [31:0] pc);
    return 32'h0000_1000 | ((pc * 32'd13) & 32'h0000_0FFC);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fetch_ready = 1'b1;
    ex_resolve_valid = 1'b0;
    ex_mispredict = 1'b0;
    ex_taken = 1'b0;
    ex_pc = '0;
    ex_target = '0;
    btb_hit = 1'b0;
    btb_target = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", fetch_valid); end
    checks++;
    if (fetch_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got=%b exp=0", fetch_pred_taken); end
    checks++;
    if (btb_pc !== 32'h100) begin errors++; $display("FAIL reset_btb_pc got=%h exp=00000100", btb_pc); end
    checks++;
    if (fetch_valid2 !== 1'b0) begin errors++; $display("FAIL reset_valid2 got=%b exp=0", fetch_valid2); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      exp_pc = 32'h100 + 32'(4 * k);
      cyc();
      @(negedge clk);
      checks++;
      if (fetch_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got=%b exp=1", k, fetch_valid); end
      checks++;
      if (fetch_pc !== exp_pc) begin errors++; $display("FAIL seq_pc[%0d] got=%h exp=%h", k, fetch_pc, exp_pc); end
      checks++;
      if (fetch_pred_taken !== 1'b0) begin errors++; $display("FAIL seq_taken[%0d] got=%b exp=0", k, fetch_pred_taken); end
      checks++;
      if (fetch_pred_target !== exp_pc + 32'd4) begin
        errors++; $display("FAIL seq_target[%0d] got=%h exp=%h", k, fetch_pred_target, exp_pc + 32'd4);
      end
    end
  endtask

  task automatic test_taken_handoff();
    do_reset();
    cyc();
    cyc();
    btb_hit = 1'b1;
    btb_target = 32'h200;
    @(negedge clk);
    checks++;
    if (fetch_pc !== 32'h104 || fetch_pred_taken !== 1'b1 || fetch_pred_target !== 32'h200) begin
      errors++; $display("FAIL taken_pred got pc=%h tk=%b tgt=%h exp pc=00000104 tk=1 tgt=00000200",
                         fetch_pc, fetch_pred_taken, fetch_pred_target);
    end
    cyc();
    btb_hit = 1'b0;
    @(negedge clk);
    checks++;
    if (fetch_valid !== 1'b0) begin errors++; $display("FAIL taken_bubble got=%b exp=0", fetch_valid); end
    cyc();
    @(negedge clk);
    checks++;
    if (fetch_valid !== 1'b1 || fetch_pc !== 32'h200) begin
      errors++; $display("FAIL taken_redirect got v=%b pc=%h exp v=1 pc=00000200", fetch_valid, fetch_pc);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (fetch_pc !== 32'h204) begin errors++; $display("FAIL taken_next got=%h exp=00000204", fetch_pc); end
  endtask

  task automatic test_stall_hold();
    do_reset();
    cyc();
    cyc();
    btb_hit = 1'b1;
    btb_target = 32'h200;
    fetch_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        cyc();
        btb_hit = 1'b0;
        btb_target = 32'hDEAD_BEE0;
        fetch_ready = (k == 3);
      end
      @(negedge clk);
      checks++;
      if (fetch_valid !== 1'b1 || fetch_pc !== 32'h104 || fetch_pred_taken !== 1'b1 ||
          fetch_pred_target !== 32'h200) begin
        errors++; $display("FAIL stall_hold[%0d] got v=%b pc=%h tk=%b tgt=%h exp v=1 pc=00000104 tk=1 tgt=00000200",
                           k, fetch_valid, fetch_pc, fetch_pred_taken, fetch_pred_target);
      end
      checks++;
      if (btb_pc !== 32'h108) begin errors++; $display("FAIL stall_btb_pc[%0d] got=%h exp=00000108", k, btb_pc); end
    end
    cyc();
    @(negedge clk);
    checks++;
    if (fetch_valid !== 1'b0) begin errors++; $display("FAIL stall_bubble got=%b exp=0", fetch_valid); end
    cyc();
    @(negedge clk);
    checks++;
    if (fetch_pc !== 32'h200 || fetch_valid !== 1'b1) begin
      errors++; $display("FAIL stall_redirect got v=%b pc=%h exp v=1 pc=00000200", fetch_valid, fetch_pc);
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    cyc();
    ex_resolve_valid = 1'b1;
    ex_mispredict = 1'b1;
    ex_taken = 1'b0;
    ex_pc = 32'h300;
    ex_target = 32'h380;
    @(negedge clk);
    checks++;
    if (btb_pc !== 32'h300 || btb_branch_update !== 1'b1) begin
      errors++; $display("FAIL mis_btb_port got pc=%h upd=%b exp pc=00000300 upd=1", btb_pc, btb_branch_update);
    end
    cyc();
    ex_resolve_valid = 1'b0;
    ex_mispredict = 1'b0;
    @(negedge clk);
    checks++;
    if (fetch_valid !== 1'b0) begin errors++; $display("FAIL mis_nt_bubble got=%b exp=0", fetch_valid); end
    cyc();
    @(negedge clk);
    checks++;
    if (fetch_pc !== 32'h304 || fetch_valid !== 1'b1) begin
      errors++; $display("FAIL mis_nt_pc got v=%b pc=%h exp v=1 pc=00000304", fetch_valid, fetch_pc);
    end
    cyc();
    fetch_ready = 1'b0;
    ex_resolve_valid = 1'b1;
    ex_mispredict = 1'b1;
    ex_taken = 1'b1;
    ex_target = 32'h500;
    cyc();
    fetch_ready = 1'b1;
    ex_resolve_valid = 1'b0;
    ex_mispredict = 1'b0;
    @(negedge clk);
    checks++;
    if (fetch_valid !== 1'b0) begin errors++; $display("FAIL mis_tk_bubble got=%b exp=0", fetch_valid); end
    cyc();
    @(negedge clk);
    checks++;
    if (fetch_pc !== 32'h500 || fetch_valid !== 1'b1) begin
      errors++; $display("FAIL mis_tk_pc got v=%b pc=%h exp v=1 pc=00000500", fetch_valid, fetch_pc);
    end
  endtask

  task automatic test_update_mux();
    do_reset();
    cyc();
    cyc();
    ex_resolve_valid = 1'b1;
    ex_mispredict = 1'b0;
    ex_pc = 32'h400;
    ex_taken = 1'b1;
    ex_target = 32'h480;
    @(negedge clk);
    checks++;
    if (btb_pc !== 32'h400 || btb_branch_update !== 1'b1 || btb_branch_taken !== 1'b1 ||
        btb_target_addr !== 32'h480) begin
      errors++; $display("FAIL upd_port got pc=%h upd=%b tk=%b tgt=%h exp pc=00000400 upd=1 tk=1 tgt=00000480",
                         btb_pc, btb_branch_update, btb_branch_taken, btb_target_addr);
    end
    cyc();
    ex_resolve_valid = 1'b0;
    btb_hit = 1'b1;
    btb_target = 32'h600;
    @(negedge clk);
    checks++;
    if (fetch_pc !== 32'h108 || fetch_pred_taken !== 1'b0 || fetch_pred_target !== 32'h10C) begin
      errors++; $display("FAIL upd_lookup_lost got pc=%h tk=%b tgt=%h exp pc=00000108 tk=0 tgt=0000010c",
                         fetch_pc, fetch_pred_taken, fetch_pred_target);
    end
    checks++;
    if (btb_pc !== 32'h10C) begin errors++; $display("FAIL upd_btb_pc_back got=%h exp=0000010c", btb_pc); end
  endtask

  task automatic test_wrap_and_reset_in_stall();
    do_reset();
    ex_taken = 1'b1;
    ex_target = 32'h0000_0ABC;
    cyc();
    @(negedge clk);
    checks++;
    if (fetch_pc2 !== 32'hFFFF_FFFC || fetch_pred_target2 !== 32'h0 || btb_pc2 !== 32'h0) begin
      errors++; $display("FAIL wrap_first got pc=%h tgt=%h bpc=%h exp pc=fffffffc tgt=00000000 bpc=00000000",
                         fetch_pc2, fetch_pred_target2, btb_pc2);
    end
    checks++;
    if (fetch_pred_taken2 !== 1'b0 || btb_branch_update2 !== 1'b0 || btb_branch_taken2 !== 1'b1 ||
        btb_target_addr2 !== 32'h0000_0ABC) begin
      errors++; $display("FAIL wrap_ports got tk=%b upd=%b btk=%b bta=%h exp tk=0 upd=0 btk=1 bta=00000abc",
                         fetch_pred_taken2, btb_branch_update2, btb_branch_taken2, btb_target_addr2);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (fetch_pc2 !== 32'h0 || fetch_valid2 !== 1'b1) begin
      errors++; $display("FAIL wrap_second got v=%b pc=%h exp v=1 pc=00000000", fetch_valid2, fetch_pc2);
    end
    cyc();
    fetch_ready = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    fetch_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (fetch_valid !== 1'b0 || fetch_valid2 !== 1'b0) begin
      errors++; $display("FAIL rst_stall_valid got v=%b v2=%b exp 0 0", fetch_valid, fetch_valid2);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (fetch_pc !== 32'h100 || fetch_pc2 !== 32'hFFFF_FFFC || fetch_valid !== 1'b1) begin
      errors++; $display("FAIL rst_restart got pc=%h pc2=%h v=%b exp pc=00000100 pc2=fffffffc v=1",
                         fetch_pc, fetch_pc2, fetch_valid);
    end
  endtask

  // Model view: one F1 slot whose prediction is fixed when the PC enters it.
  task automatic test_random();
    logic        m_valid, m_taken, rv, mp, rdy;
    logic [31:0] m_pc, m_target, m_next, stub_pc, exp_tgt, exp_bpc;
    int          err_before;
    do_reset();
    m_valid = 1'b0;
    m_taken = 1'b0;
    m_pc = '0;
    m_target = '0;
    m_next = 32'h100;
    err_before = errors;
    for (int i = 0; i < 600; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 6) == 0);
      mp  = ($urandom_range(0, 1) == 1);
      fetch_ready = rdy;
      ex_resolve_valid = rv;
      ex_mispredict = mp;
      ex_taken = ($urandom_range(0, 1) == 1);
      ex_pc = 32'h1000 + 32'(4 * $urandom_range(0, 1023));
      ex_target = 32'h1000 + 32'(4 * $urandom_range(0, 1023));
      @(negedge clk);
      exp_bpc = rv ? ex_pc : m_next;
      checks++;
      if (btb_pc !== exp_bpc || btb_branch_update !== rv) begin
        errors++; $display("FAIL rnd_btb_port[%0d] got pc=%h upd=%b exp pc=%h upd=%b", i, btb_pc, btb_branch_update, exp_bpc, rv);
      end
      checks++;
      if (fetch_valid !== m_valid) begin
        errors++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, fetch_valid, m_valid);
      end else if (m_valid) begin
        exp_tgt = m_taken ? m_target : m_pc + 32'd4;
        checks++;
        if (fetch_pc !== m_pc || fetch_pred_taken !== m_taken || fetch_pred_target !== exp_tgt) begin
          errors++; $display("FAIL rnd_slot[%0d] got pc=%h tk=%b tgt=%h exp pc=%h tk=%b tgt=%h",
                             i, fetch_pc, fetch_pred_taken, fetch_pred_target, m_pc, m_taken, exp_tgt);
        end
      end else begin
        checks++;
        if (fetch_pred_taken !== 1'b0) begin errors++; $display("FAIL rnd_idle_taken[%0d] got=%b exp=0", i, fetch_pred_taken); end
      end
      stub_pc = btb_pc;
      if (rv && mp) begin
        m_valid = 1'b0;
        m_next = ex_taken ? ex_target : ex_pc + 32'd4;
      end else if (m_valid && m_taken && rdy) begin
        m_valid = 1'b0;
        m_next = m_target;
      end else if (!m_valid || rdy) begin
        m_valid = 1'b1;
        m_pc = m_next;
        m_taken = !rv && tbl_hit(m_next);
        m_target = tbl_tgt(m_next);
        m_next = m_next + 32'd4;
      end
      cyc();
      btb_hit = tbl_hit(stub_pc);
      btb_target = tbl_tgt(stub_pc);
      if (errors - err_before > 10) break;
    end
  endtask

  initial begin
    rst = 1'b1;
    fetch_ready = 1'b1;
    ex_resolve_valid = 1'b0;
    ex_mispredict = 1'b0;
    ex_taken = 1'b0;
    ex_pc = '0;
    ex_target = '0;
    btb_hit = 1'b0;
    btb_target = '0;
    test_reset();
    test_sequential();
    test_taken_handoff();
    test_stall_hold();
    test_mispredict();
    test_update_mux();
    test_wrap_and_reset_in_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
